// File: rtl/text_normalizer.sv
// Character-stream conditioning stage: strips '#' comments, folds case, collapses
// whitespace to one space, drops non-printables, and buffers the result in a FIFO.
module text_normalizer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out,
  input  logic        out_ready,
  output logic [15:0] emit_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  typedef enum logic {S_TEXT, S_COMMENT} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_last_space, w_ls_nxt;
  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [AW:0]     r_occ;
  logic [15:0]     r_emit;

  logic            w_accept, w_push, w_pop;
  logic            w_is_space, w_is_hash, w_is_char;
  logic [7:0]      w_char, w_wdata;

  // Reset gates the handshake so a byte offered in the reset cycle is never taken.
  assign in_ready   = !reset && (r_occ < L_FULL);
  assign out_valid  = (r_occ != '0);
  assign out        = out_valid ? r_mem[r_rptr] : 8'h00;
  assign emit_count = r_emit;
  assign w_accept   = in_valid && in_ready;
  assign w_pop      = out_valid && out_ready;

  always_comb begin
    w_is_space = (in == 8'h0A) || (in == 8'h0D) || (in == 8'h09) || (in == 8'h20);
    w_is_hash  = (in == 8'h23);
    w_is_char  = !w_is_hash && (in >= 8'h21) && (in <= 8'h7E);
    w_char     = ((in >= 8'h41) && (in <= 8'h5A)) ? (in + 8'h20) : in;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_wdata     = 8'h20;
    w_ls_nxt    = r_last_space;
    if (w_accept) begin
      case (r_state)
        S_TEXT: begin
          if (w_is_hash) begin
            w_state_nxt = S_COMMENT;
          end else if (w_is_space) begin
            if (!r_last_space) begin
              w_push   = 1'b1;
              w_ls_nxt = 1'b1;
            end
          end else if (w_is_char) begin
            w_push   = 1'b1;
            w_wdata  = w_char;
            w_ls_nxt = 1'b0;
          end
        end
        S_COMMENT: begin
          // Only LF ends a comment; it stands in for the whitespace the comment replaced.
          if (in == 8'h0A) begin
            w_state_nxt = S_TEXT;
            if (!r_last_space) begin
              w_push   = 1'b1;
              w_ls_nxt = 1'b1;
            end
          end
        end
        default: w_state_nxt = S_TEXT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_TEXT;
      r_last_space <= 1'b1;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_occ        <= '0;
      r_emit       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_space <= w_ls_nxt;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
      if (w_push && (r_emit != 16'hFFFF)) r_emit <= r_emit + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_wdata;
  end
endmodule

// File: tb/tb_text_normalizer.sv
// Directed self-checking bench for text_normalizer (DEPTH=4).
module tb_text_normalizer;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_b;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_b;
  logic        out_ready;
  logic [15:0] emit_count;

  int total = 0;
  int bad   = 0;
  logic [7:0] got[$];
  bit collect = 1'b1;

  text_normalizer #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_b), .in_ready(in_ready),
    .out_valid(out_valid), .out(out_b), .out_ready(out_ready), .emit_count(emit_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (collect && out_valid && out_ready) got.push_back(out_b);

  function automatic string q2s();
    string s = "";
    foreach (got[i]) s = $sformatf("%s%c", s, got[i]);
    return s;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    got.delete();
  endtask

  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_b = b;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        total++; bad++;
        $display("FAIL push_timeout byte=%02h in_ready stuck at 0, need 1", b);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) push_byte(s[i]);
  endtask

  task automatic drain();
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic check_str(input string name, input string exp);
    string s;
    s = q2s();
    total++;
    if (s != exp) begin
      bad++;
      $display("FAIL %s got \"%s\" need \"%s\"", name, s, exp);
    end
  endtask

  task automatic check_cnt(input string name, input logic [15:0] exp);
    total++;
    if (emit_count !== exp) begin
      bad++;
      $display("FAIL %s emit_count=%0d need %0d", name, emit_count, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_b = 8'h00; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1)   begin bad++; $display("FAIL rst_in_ready got %b need 1", in_ready); end
    total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL rst_out_valid got %b need 0", out_valid); end
    total++; if (out_b !== 8'h00)     begin bad++; $display("FAIL rst_out got %02h need 00", out_b); end
    total++; if (emit_count !== 16'd0) begin bad++; $display("FAIL rst_emit got %0d need 0", emit_count); end
  endtask

  task automatic test_fold();
    do_reset();
    out_ready = 1'b1;
    push_str("  ");
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fold_leading_space out_valid=%b need 0", out_valid); end
    @(posedge clk); #1;
    push_byte("B");
    @(negedge clk);
    total++;
    if (!(out_valid === 1'b1 && out_b === 8'h62)) begin
      bad++; $display("FAIL fold_latency out_valid=%b out=%02h need 1/62", out_valid, out_b);
    end
    @(posedge clk); #1;
    push_str("eGiN\t\tEnd\n");
    drain();
    check_str("fold_stream", "begin end ");
    check_cnt("fold_count", 16'd10);
  endtask

  task automatic test_comment();
    do_reset();
    out_ready = 1'b1;
    push_str("a#x y\nb");
    drain();
    check_str("comment_stream", "a b");
    check_cnt("comment_count", 16'd3);
  endtask

  task automatic test_drop();
    logic [7:0] v[5] = '{8'h00, 8'h7F, 8'h80, 8'h71, 8'h1B};
    int miss = 0;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_b = v[i];
      @(negedge clk);
      if (!in_ready) miss++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++; if (miss != 0) begin bad++; $display("FAIL drop_handshake stalled cycles=%0d need 0", miss); end
    drain();
    check_str("drop_stream", "q");
    check_cnt("drop_count", 16'd1);
  endtask

  task automatic test_backpressure();
    int unstable = 0;
    do_reset();
    out_ready = 1'b0;
    push_str("abcd");
    in_valid = 1'b1; in_b = "e";
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full in_ready=%b need 0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (!(out_valid === 1'b1 && out_b === 8'h61)) unstable++;
    end
    total++; if (unstable != 0) begin bad++; $display("FAIL bp_hold head unstable cycles=%0d need 0", unstable); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_pop_cycle in_ready=%b need 0", in_ready); end
    @(posedge clk);
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_after_pop in_ready=%b need 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    push_byte("f");
    drain();
    check_str("bp_stream", "abcdef");
    check_cnt("bp_count", 16'd6);
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    push_str("abc#zz");
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b1; in_b = "q";
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0)   begin bad++; $display("FAIL mid_out_valid got %b need 0", out_valid); end
    total++; if (out_b !== 8'h00)      begin bad++; $display("FAIL mid_out got %02h need 00", out_b); end
    total++; if (in_ready !== 1'b1)    begin bad++; $display("FAIL mid_in_ready got %b need 1", in_ready); end
    total++; if (emit_count !== 16'd0) begin bad++; $display("FAIL mid_emit got %0d need 0", emit_count); end
    got.delete();
    @(posedge clk); #1;
    out_ready = 1'b1;
    push_str("x");
    drain();
    check_str("mid_stream", "x");
    check_cnt("mid_count", 16'd1);
  endtask

  task automatic test_saturation();
    int errs = 0;
    int stalls = 0;
    logic [15:0] at_edge = 16'h0;
    do_reset();
    collect = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      in_valid = 1'b1;
      in_b = 8'h61 + 8'(i % 26);
      @(negedge clk);
      if (!in_ready) stalls++;
      if (i > 0 && !(out_valid === 1'b1 && out_b === 8'h61 + 8'((i - 1) % 26))) errs++;
      if (i == 65534) at_edge = emit_count;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
    collect = 1'b1;
    total++; if (errs != 0 || stalls != 0) begin bad++; $display("FAIL sat_stream errs=%0d stalls=%0d need 0/0", errs, stalls); end
    total++; if (at_edge !== 16'hFFFE) begin bad++; $display("FAIL sat_pre emit_count=%04h need FFFE", at_edge); end
    check_cnt("sat_hold", 16'hFFFF);
  endtask

  initial begin
    test_reset();
    test_fold();
    test_comment();
    test_drop();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/text_normalizer.md
# text_normalizer

Upstream character-stream conditioning stage that sits directly in front of the begin/end block checker. It accepts raw ASCII bytes with a valid/ready handshake and strips `#` comments. It folds case, maps whitespace to a single space, and drops non-printables. The cleaned stream is buffered in a small FIFO and presented one character per cycle for the checker to consume.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `clk` input 1: the only clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-high; clears FIFO, state machine, flags and counter.
- `in_valid` input 1: upstream byte valid.
- `in` input 8: raw ASCII byte.
- `in_ready` output 1: stage can accept a byte this cycle.
- `out_valid` output 1: FIFO head holds a normalized character.
- `out` output 8: normalized character; 0x00 when `out_valid`=0.
- `out_ready` input 1: downstream takes the head this cycle.
- `emit_count` output 16: characters written into the FIFO since reset; saturates at 0xFFFF.

## Operation
- Accept: byte is consumed when `in_valid && in_ready`.
- `in_ready` = (occupancy < DEPTH). It is independent of `out_ready`, so a full FIFO never accepts, even during a pop.
- Classification of an accepted byte, in priority order:
  - LF 0x0A, CR 0x0D, TAB 0x09, SP 0x20: class SPACE.
  - `#` 0x23: class HASH.
  - 'A'..'Z': lowercased (+0x20), class CHAR.
  - 0x21..0x7E otherwise: class CHAR, unchanged.
  - All other values (0x00..0x1F except above, 0x7F..0xFF): class DROP.
- State machine, two states:
  - TEXT (reset state):
    - HASH: go to COMMENT; nothing written.
    - SPACE: write 0x20 only if `last_space`=0.
    - CHAR: write the byte.
    - DROP: nothing written.
  - COMMENT:
    - LF 0x0A: return to TEXT and write 0x20 if `last_space`=0.
    - Any other byte, including CR and `#`: discarded, state unchanged.
- `last_space` flag:
  - Reset value 1, so leading spaces are suppressed.
  - Set when 0x20 is written.
  - Cleared when a CHAR is written.
  - Unchanged by DROP or discarded bytes.
- Written bytes: every written byte is emitted downstream exactly once, in order. Filtered bytes still complete the input handshake; they occupy no FIFO slot.
- Pop: head is removed when `out_valid && out_ready`.
- `emit_count`: increments by 1 on every FIFO write, holds at 0xFFFF.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out`=0x00, `emit_count`=0, state TEXT, `last_space`=1, occupancy 0.
- Latency: a byte accepted in cycle N that produces a write appears at the head (`out_valid`=1) in cycle N+1 at the earliest, when the FIFO was empty or popped to it. There is no combinational in→out path.
- Simultaneous push and pop (FIFO not full): occupancy unchanged, order preserved.
- Pop and push into an empty FIFO:
  - The pop in cycle N is impossible, since `out_valid`=0.
  - The write lands and is visible in N+1.
- Full FIFO with `out_ready`=1: the pop happens; `in_ready` rises in the following cycle.
- Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is log2(DEPTH)+1 bits.
- Reset asserted mid-stream, including in COMMENT or while full:
  - Next cycle all outputs are at reset values.
  - FIFO contents are discarded.
  - Any byte presented during the reset cycle is not accepted.
- `out` and `out_valid` are stable while `out_valid && !out_ready` (hold-until-taken).

## Test plan
- Case fold and collapse: "  BeGiN\t\tEnd\n", out_ready=1 → output "begin end ", emit_count=10; the first output appears one cycle after 'B' is accepted.
- Comment strip: "a#x y\nb" → output "a b", emit_count=3. Bytes 'x', ' ', 'y' produce no write; the LF emits the space.
- Drop class: bytes 0x00, 0x7F, 0x80, 'q', 0x1B → output "q" only; all five handshakes complete in five consecutive cycles.
- Backpressure with DEPTH=4: hold out_ready=0 and stream "abcdef".
  - `in_ready` falls after 4 accepts.
  - Release → "abcdef" in order, with the pointer wrap exercised.
  - `in_ready` returns 1 the cycle after the first pop.
- Reset mid-operation: fill 3 entries, enter COMMENT, pulse reset one cycle, then send "x" → out_valid=0 after reset, then output "x"; emit_count=1.
- Saturation: force 65 540 CHAR writes with out_ready=1 → emit_count holds at 0xFFFF; output stream uninterrupted.
